// File: rtl/uart_rx_oversampler_if.sv
// UART receive bundle: serial side inputs and
// per-frame result outputs of the receive stage.
interface uart_rx_oversampler_if #(
  parameter int DATA_BITS = 8
);
  logic                 os_clk;
  logic                 rx;
  logic [1:0]           parity_mode;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output os_clk,
    output rx,
    output parity_mode,
    input  data,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  os_clk,
    input  rx,
    input  parity_mode,
    output data,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_oversampler.sv
// UART receiver: 16x oversampled deserialiser
// with parity and framing checks.
module uart_rx_oversampler #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input logic clk,
  input logic rst,
  uart_rx_oversampler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  localparam logic [3:0] MID =
    4'(OS_RATE / 2 - 1);
  localparam logic [3:0] LAST =
    4'(OS_RATE - 1);
  localparam logic [2:0] BIT_LAST =
    3'(DATA_BITS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_os_q;
  logic                 r_os_prev;
  logic                 w_tick;
  logic [3:0]           r_tick_cnt;
  logic [3:0]           w_tick_nxt;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_par;
  logic                 w_par_nxt;
  logic [1:0]           r_mode;
  logic [1:0]           w_mode_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 w_par_en;
  logic                 w_done;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr;

  assign w_tick   = r_os_q & ~r_os_prev;
  assign w_par_en = (r_mode == 2'b01) |
                    (r_mode == 2'b10);

  // rx synchroniser and os_clk edge capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_os_q    <= 1'b1;
      r_os_prev <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
      r_os_q    <= bus.os_clk;
      r_os_prev <= r_os_q;
    end
  end

  // FSM state and frame datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_mode     <= 2'b00;
      r_perr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_mode     <= w_mode_nxt;
      r_perr     <= w_perr_nxt;
    end
  end

  // next-state and datapath update, tick-gated
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_mode_nxt  = r_mode;
    w_perr_nxt  = r_perr;
    w_done      = 1'b0;
    if (w_tick) begin
      w_tick_nxt = r_tick_cnt + 4'd1;
      unique case (r_state)
        S_IDLE: begin
          w_tick_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (r_tick_cnt == MID) begin
            if (r_rx_s) begin
              w_state_nxt = S_IDLE;
              w_tick_nxt  = '0;
            end else begin
              w_state_nxt = S_DATA;
              w_mode_nxt  = bus.parity_mode;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
              w_par_nxt   = 1'b0;
              w_perr_nxt  = 1'b0;
            end
          end
        end
        S_DATA: begin
          if (r_tick_cnt == LAST) begin
            w_shift_nxt = {r_rx_s,
              r_shift[DATA_BITS-1:1]};
            w_par_nxt = r_par ^ r_rx_s;
            w_bit_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = w_par_en ?
                S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == LAST) begin
            if (r_mode == 2'b10) begin
              w_perr_nxt = ~(r_par ^ r_rx_s);
            end else begin
              w_perr_nxt = r_par ^ r_rx_s;
            end
            w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == LAST) begin
            w_done      = 1'b1;
            w_state_nxt = r_rx_s ?
              S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // frame result registers and valid strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data   <= r_shift;
        r_perr_o <= r_perr;
        r_ferr   <= ~r_rx_s;
      end
    end
  end

  assign bus.data       = r_data;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_perr_o;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler:
// hand-computed frames, os_clk = clk/4.
module tb_uart_rx_oversampler;

  localparam int BIT = 640;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   dv_cnt = 0;
  int   wide_cnt = 0;
  logic dv_prev = 1'b0;
  logic [7:0] log_q[$];
  int   n0;
  int   idx;

  uart_rx_oversampler_if #(.DATA_BITS(8)) u_if ();

  uart_rx_oversampler #(
    .DATA_BITS(8),
    .OS_RATE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  initial u_if.os_clk = 1'b0;
  always #20 u_if.os_clk = ~u_if.os_clk;

  always @(negedge clk) begin
    if (u_if.data_valid) begin
      dv_cnt <= dv_cnt + 1;
      log_q.push_back(u_if.data);
      if (dv_prev) wide_cnt <= wide_cnt + 1;
    end
    dv_prev <= u_if.data_valid;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       use_par,
    input logic       pb,
    input logic       sb
  );
    u_if.rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      #(BIT);
    end
    if (use_par) begin
      u_if.rx = pb;
      #(BIT);
    end
    u_if.rx = sb;
    #(BIT);
  endtask

  task automatic chk_frame(
    input string      tag,
    input logic [7:0] d,
    input logic       pe,
    input logic       fe
  );
    chk({tag, "_dv"}, 32'(dv_cnt - n0), 32'd1);
    chk({tag, "_data"}, 32'(u_if.data),
        32'(d));
    chk({tag, "_perr"}, 32'(u_if.parity_err),
        32'(pe));
    chk({tag, "_ferr"}, 32'(u_if.frame_err),
        32'(fe));
  endtask

  initial begin
    u_if.rx = 1'b1;
    u_if.parity_mode = 2'b00;
    #103;
    chk("rst_data", 32'(u_if.data), 32'h0);
    chk("rst_dv", 32'(u_if.data_valid), 32'h0);
    chk("rst_perr", 32'(u_if.parity_err), 32'h0);
    chk("rst_ferr", 32'(u_if.frame_err), 32'h0);
    chk("rst_busy", 32'(u_if.busy), 32'h0);
    rst = 1'b1;
    #(BIT);

    n0 = dv_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    #(BIT);
    chk_frame("f55", 8'h55, 1'b0, 1'b0);
    chk("f55_busy", 32'(u_if.busy), 32'h0);

    u_if.parity_mode = 2'b01;
    n0 = dv_cnt;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    #(BIT);
    chk_frame("evn_ok", 8'hA3, 1'b0, 1'b0);

    n0 = dv_cnt;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    #(BIT);
    chk_frame("evn_bad", 8'hA3, 1'b1, 1'b0);

    u_if.parity_mode = 2'b10;
    n0 = dv_cnt;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    #(BIT);
    chk_frame("odd_ok", 8'hA3, 1'b0, 1'b0);

    u_if.parity_mode = 2'b01;
    n0 = dv_cnt;
    fork
      send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
      begin
        #(BIT * 3);
        u_if.parity_mode = 2'b00;
      end
    join
    #(BIT);
    chk_frame("mode_chg", 8'hA3, 1'b1, 1'b0);

    n0 = dv_cnt;
    u_if.rx = 1'b0;
    #120;
    u_if.rx = 1'b1;
    #40;
    chk("glitch_busy", 32'(u_if.busy), 32'h1);
    #(BIT);
    chk("glitch_idle", 32'(u_if.busy), 32'h0);
    chk("glitch_dv", 32'(dv_cnt - n0), 32'h0);

    n0 = dv_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    #1600;
    chk_frame("brk", 8'h3C, 1'b0, 1'b1);
    chk("brk_busy", 32'(u_if.busy), 32'h1);
    u_if.rx = 1'b1;
    #(BIT);
    chk("brk_rel", 32'(u_if.busy), 32'h0);
    chk("brk_once", 32'(dv_cnt - n0), 32'h1);

    n0 = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    #(BIT);
    chk_frame("f01", 8'h01, 1'b0, 1'b0);

    n0 = dv_cnt;
    idx = log_q.size();
    send_frame(8'h12, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1);
    #(BIT);
    chk("b2b_dv", 32'(dv_cnt - n0), 32'd2);
    if (log_q.size() >= idx + 2) begin
      chk("b2b_d0", 32'(log_q[idx]), 32'h12);
      chk("b2b_d1", 32'(log_q[idx+1]), 32'h34);
    end
    chk("b2b_perr", 32'(u_if.parity_err), 32'h0);
    chk("b2b_ferr", 32'(u_if.frame_err), 32'h0);

    n0 = dv_cnt;
    fork
      send_frame(8'hE5, 1'b0, 1'b0, 1'b1);
      begin
        #(BIT * 5 + 300);
        rst = 1'b0;
        #1;
        chk("mrst_data", 32'(u_if.data), 32'h0);
        chk("mrst_dv", 32'(u_if.data_valid), 32'h0);
        chk("mrst_perr", 32'(u_if.parity_err), 32'h0);
        chk("mrst_ferr", 32'(u_if.frame_err), 32'h0);
        chk("mrst_busy", 32'(u_if.busy), 32'h0);
        #400;
        rst = 1'b1;
      end
    join
    #(BIT);
    chk("mrst_nodv", 32'(dv_cnt - n0), 32'h0);

    n0 = dv_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    #(BIT);
    chk_frame("fFF", 8'hFF, 1'b0, 1'b0);

    chk("dv_width", 32'(wide_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
